shift_sequencer: RTL and testbench
==================================

// Module: shift_sequencer
// PURPOSE
//  Multi-cycle controller for the ALU shift path: accepts a 20-bit operand, a 6-bit shift amount and an op code.
//  Completes shifts/rotates of up to 63 positions by iterating a single shift stage of at most STEP_MAX bits per cycle.
//  Sits between the ALU operand latches and the writeback mux; valid/ready on both sides.
// PARAMETERS
//  WIDTH     20  operand/result width in bits
//  AMT_W      6  shift-amount width (0..63)
//  STEP_MAX  15  max positions applied per SHIFT cycle (4-bit stage limit)
// PORTS
//  clk        in   1        system clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        request present
//  in_ready   out  1        controller can accept (high only in IDLE)
//  in_data    in   WIDTH    operand
//  in_amt     in   AMT_W    shift amount
//  in_op      in   2        00 SLL, 01 SRL, 10 SRA, 11 ROL
//  out_valid  out  1        result present (high only in DONE)
//  out_ready  in   1        consumer accepts result
//  out_data   out  WIDTH    result, registered
//  busy       out  1        high in SHIFT or DONE
// BEHAVIOUR
//  Reset (rst_n low, async): state=IDLE; acc, remaining, op cleared.
//   Outputs during/after reset: in_ready=1, out_valid=0, out_data=0, busy=0.
//  States: IDLE -> SHIFT -> DONE -> IDLE.
//  IDLE: in_ready=1.
//   Accept on in_valid&&in_ready (cycle T): latch in_data->acc, in_op.
//   Set remaining = (op==ROL) ? in_amt : min(in_amt, WIDTH).
//   Next state is SHIFT if remaining!=0, else DONE.
//  SHIFT: each cycle step=min(remaining,STEP_MAX); acc updated by step per op; remaining-=step.
//   When remaining reaches 0 after the update, go to DONE.
//   Passes = ceil(remaining_initial/STEP_MAX).
//   Max 2 passes for shifts, 5 for ROL (63 = 15+15+15+15+3).
//  Op rules per step:
//   SLL zero-fills at LSB; SRL zero-fills at MSB; SRA replicates acc[WIDTH-1].
//   ROL wraps MSBs into LSBs. ROL by k == ROL by (k mod WIDTH).
//  Clamp: shift amounts >= WIDTH yield all-zero (SLL/SRL) or all-sign (SRA).
//  DONE: out_valid=1, out_data=acc.
//   Go to IDLE on out_valid&&out_ready.
//   Until then out_data is stable and in_ready=0.
//   No accept in the same cycle as result handoff; earliest new accept is the following cycle.
//  Latency: out_valid rises at cycle T+1+passes (amt 0 -> T+1).
//  Inputs are sampled only at accept; changes to in_* while busy are ignored.
//  in_valid while busy: request is not accepted and is not lost by the controller; the requester must hold it.
//  rst_n asserted in SHIFT or DONE aborts the operation immediately; the result is discarded and all outputs take reset values.
// TESTING
//  SLL in_data=0x0000A amt=1, out_ready=1 -> out_data=0x00014, out_valid at T+2 for 1 cycle.
//  SLL 0x00001 amt=19 -> 0x80000 after 2 passes (15+4), out_valid at T+3.
//  SRA 0x80000 amt=40 -> clamped to 20, out_data=0xFFFFF at T+3.
//  SRL 0x80000 amt=40 -> 0x00000 at T+3.
//  ROL 0x00001 amt=21 -> 0x00002 (15+6 passes) at T+3.
//  ROL 0x00001 amt=63 -> 0x00008 (5 passes) at T+6.
//  SRL 0x12345 amt=0 -> 0x12345 at T+1, zero SHIFT cycles.
//  Backpressure: hold out_ready=0 for 3 cycles in DONE -> out_data/out_valid stable, in_ready=0, extra in_valid not accepted.
//   Then out_ready=1 -> IDLE next cycle.
//  Async reset: pulse rst_n low mid-SHIFT of ROL amt=63 (between edges) -> out_valid=0, out_data=0, in_ready=1 immediately.
//   Next request then completes normally.

Source files
------------

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate controller: applies up to STEP_MAX positions per cycle
// until the requested amount is consumed, then holds the result until taken.
module shift_sequencer #(
  parameter int WIDTH    = 20,
  parameter int AMT_W    = 6,
  parameter int STEP_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  localparam logic [AMT_W-1:0] STEP_LIM = AMT_W'(STEP_MAX);
  localparam logic [AMT_W-1:0] WIDTH_AMT = AMT_W'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [AMT_W-1:0] rem_q;
  logic [1:0]       op_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic [WIDTH-1:0] out_data_q;

  logic [AMT_W-1:0] step_d;
  logic [AMT_W-1:0] rem_d;
  logic [AMT_W-1:0] rem_init_d;
  logic [WIDTH-1:0] acc_d;

  // Linear shifts saturate at WIDTH (the fill fully replaces the operand);
  // rotates keep the raw amount and simply wrap around.
  always_comb begin
    rem_init_d = in_amt;
    if (in_op != OP_ROL && in_amt > WIDTH_AMT) begin
      rem_init_d = WIDTH_AMT;
    end
  end

  always_comb begin
    step_d = (rem_q > STEP_LIM) ? STEP_LIM : rem_q;
    rem_d  = rem_q - step_d;
    acc_d  = acc_q;
    case (op_q)
      OP_SLL:  acc_d = acc_q << step_d;
      OP_SRL:  acc_d = acc_q >> step_d;
      OP_SRA:  acc_d = $signed(acc_q) >>> step_d;
      OP_ROL:  acc_d = (acc_q << step_d) | (acc_q >> (WIDTH_AMT - step_d));
      default: acc_d = acc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      rem_q       <= '0;
      op_q        <= OP_SLL;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            acc_q      <= in_data;
            op_q       <= in_op;
            rem_q      <= rem_init_d;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (rem_init_d == '0) begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
              out_data_q  <= in_data;
            end else begin
              state_q <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          acc_q <= acc_d;
          rem_q <= rem_d;
          if (rem_d == '0) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            out_data_q  <= acc_d;
          end
        end
        S_DONE: begin
          // The handoff cycle only returns to IDLE; a new accept waits a cycle.
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: hand-computed results, cycle-exact latency,
// backpressure and mid-operation asynchronous reset.
module tb_shift_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_data;
  logic [5:0]  in_amt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_data;
  logic        busy;

  int total = 0;
  int bad   = 0;

  shift_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_amt   (in_amt),
    .in_op    (in_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one request, then check out_valid stays low for exactly `passes`
  // cycles, rises with the expected data, and drops after a one-cycle handoff.
  task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [19:0] data,
                               input logic [5:0] amt, input logic [19:0] exp, input int passes);
    @(negedge clk);
    in_op     = op;
    in_data   = data;
    in_amt    = amt;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    checkOutput({tag, " ready_pre"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 20'h0;
    in_amt   = 6'd0;
    for (int i = 0; i < passes; i++) begin
      checkOutput({tag, " valid_early"}, 32'(out_valid), 32'd0);
      checkOutput({tag, " busy_shift"}, 32'(busy), 32'd1);
      @(posedge clk);
      #1;
    end
    checkOutput({tag, " valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, " data"}, 32'(out_data), 32'(exp));
    checkOutput({tag, " ready_done"}, 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput({tag, " valid_drop"}, 32'(out_valid), 32'd0);
    checkOutput({tag, " ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 20'h0;
    in_amt    = 6'd0;
    in_op     = 2'b00;
    out_ready = 1'b1;
    #12;
    checkOutput("rst in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst out_data", 32'(out_data), 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("sll1",    2'b00, 20'h0000A, 6'd1,  20'h00014, 1);
    applyStimulus("sll19",   2'b00, 20'h00001, 6'd19, 20'h80000, 2);
    applyStimulus("sra40",   2'b10, 20'h80000, 6'd40, 20'hFFFFF, 2);
    applyStimulus("srl40",   2'b01, 20'h80000, 6'd40, 20'h00000, 2);
    applyStimulus("rol21",   2'b11, 20'h00001, 6'd21, 20'h00002, 2);
    applyStimulus("rol63",   2'b11, 20'h00001, 6'd63, 20'h00008, 5);
    applyStimulus("srl0",    2'b01, 20'h12345, 6'd0,  20'h12345, 0);
    applyStimulus("sra4",    2'b10, 20'hA0000, 6'd4,  20'hFA000, 1);
    applyStimulus("sra3pos", 2'b10, 20'h40000, 6'd3,  20'h08000, 1);
    applyStimulus("rol4",    2'b11, 20'h80001, 6'd4,  20'h00018, 1);
    applyStimulus("srl20",   2'b01, 20'hFFFFF, 6'd20, 20'h00000, 2);
    applyStimulus("sll16",   2'b00, 20'h0000F, 6'd16, 20'hF0000, 2);

    // Backpressure: SLL 0x00003 by 2 -> 0x0000C, held for three cycles.
    @(negedge clk);
    in_op     = 2'b00;
    in_data   = 20'h00003;
    in_amt    = 6'd2;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 20'hABCDE;
    in_amt   = 6'd7;
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp valid", 32'(out_valid), 32'd1);
      checkOutput("bp data", 32'(out_data), 32'h0000C);
      checkOutput("bp in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    checkOutput("bp held valid", 32'(out_valid), 32'd1);
    checkOutput("bp held data", 32'(out_data), 32'h0000C);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp handoff valid", 32'(out_valid), 32'd0);
    checkOutput("bp handoff in_ready", 32'(in_ready), 32'd1);
    checkOutput("bp no accept busy", 32'(busy), 32'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("bp idle busy", 32'(busy), 32'd0);

    // Asynchronous abort in the middle of a long rotate.
    @(negedge clk);
    in_op    = 2'b11;
    in_data  = 20'h00001;
    in_amt   = 6'd63;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    checkOutput("abort busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort out_data", 32'(out_data), 32'd0);
    checkOutput("abort in_ready", 32'(in_ready), 32'd1);
    checkOutput("abort busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("post_abort", 2'b01, 20'hF0000, 6'd8, 20'h00F00, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
